// File: rtl/window_fetcher.sv
// Sliding KERNELxKERNEL window fetcher over an NxN image buffer.
// Define WINDOW_REUSE_EN to shift columns and fetch only the new column.
module window_fetcher #(
    parameter int DATA_SIZE      = 16,
    parameter int IMG_SIZE_WIDTH = 6,
    parameter int BUF_ADDR_SIZE  = 10,
    parameter int KERNEL         = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [IMG_SIZE_WIDTH-1:0] imgSize,
    output logic                      rd_en,
    output logic [BUF_ADDR_SIZE-1:0]  rd_addr,
    input  logic [DATA_SIZE-1:0]      rd_data,
    output logic [DATA_SIZE-1:0]      window [0:KERNEL*KERNEL-1],
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [IMG_SIZE_WIDTH-1:0] win_row,
    output logic [IMG_SIZE_WIDTH-1:0] win_col,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int WN    = KERNEL * KERNEL;
    localparam int KW    = $clog2(KERNEL);
    localparam int XW    = $clog2(WN);
    localparam int MAX_N = 32;
    localparam logic [KW-1:0] KL = KW'(KERNEL - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } state_t;

    state_t state;

    logic [IMG_SIZE_WIDTH-1:0] n;
    logic [IMG_SIZE_WIDTH-1:0] m_last;
    logic [IMG_SIZE_WIDTH-1:0] nxt_row;
    logic [IMG_SIZE_WIDTH-1:0] nxt_col;
    logic [KW-1:0]             iss_i;
    logic [KW-1:0]             iss_j;
    logic [KW-1:0]             nxt_i;
    logic [KW-1:0]             nxt_j;
    logic                      reuse;
    logic                      cap_en;
    logic                      cap_last;
    logic [XW-1:0]             cap_idx;
    logic                      bad_size;
    logic                      last_pos;
    logic                      wrap;
    logic                      iss_last;

    assign m_last   = n - IMG_SIZE_WIDTH'(KERNEL);
    assign bad_size = (imgSize < IMG_SIZE_WIDTH'(KERNEL)) ||
                      (imgSize > IMG_SIZE_WIDTH'(MAX_N));
    assign wrap     = (win_col == m_last);
    assign last_pos = wrap && (win_row == m_last);
    assign nxt_col  = wrap ? '0 : win_col + 1'b1;
    assign nxt_row  = wrap ? win_row + 1'b1 : win_row;
    assign iss_last = (iss_i == KL) && (iss_j == KL);

    // Column-only fetch walks i down a fixed j; full fetch is row-major.
    always_comb begin
        nxt_i = iss_i;
        nxt_j = iss_j;
        if (reuse) begin
            nxt_i = iss_i + 1'b1;
        end else if (iss_j == KL) begin
            nxt_i = iss_i + 1'b1;
            nxt_j = '0;
        end else begin
            nxt_j = iss_j + 1'b1;
        end
    end

    function automatic logic [BUF_ADDR_SIZE-1:0] addr_of(
        input logic [IMG_SIZE_WIDTH-1:0] r,
        input logic [IMG_SIZE_WIDTH-1:0] c,
        input logic [KW-1:0]             i,
        input logic [KW-1:0]             j
    );
        logic [BUF_ADDR_SIZE-1:0] ri;
        logic [BUF_ADDR_SIZE-1:0] cj;
        ri = BUF_ADDR_SIZE'(r) + BUF_ADDR_SIZE'(i);
        cj = BUF_ADDR_SIZE'(c) + BUF_ADDR_SIZE'(j);
        return ri * BUF_ADDR_SIZE'(n) + cj;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n         <= '0;
            win_row   <= '0;
            win_col   <= '0;
            iss_i     <= '0;
            iss_j     <= '0;
            reuse     <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            cap_en    <= 1'b0;
            cap_last  <= 1'b0;
            cap_idx   <= '0;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            for (int k = 0; k < WN; k++) begin
                window[k] <= '0;
            end
        end else begin
            cap_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        n       <= imgSize;
                        win_row <= '0;
                        win_col <= '0;
                        if (bad_size) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            busy    <= 1'b1;
                            reuse   <= 1'b0;
                            iss_i   <= '0;
                            iss_j   <= '0;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                        end
                    end
                end
                FETCH: begin
                    if (!enable) begin
                        state     <= IDLE;
                        rd_en     <= 1'b0;
                        win_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else begin
                        if (rd_en) begin
                            cap_en   <= 1'b1;
                            cap_idx  <= XW'(iss_i) * XW'(KERNEL) + XW'(iss_j);
                            cap_last <= iss_last;
                            if (iss_last) begin
                                rd_en <= 1'b0;
                            end else begin
                                iss_i   <= nxt_i;
                                iss_j   <= nxt_j;
                                rd_addr <= addr_of(win_row, win_col, nxt_i, nxt_j);
                            end
                        end
                        if (cap_en) begin
                            window[cap_idx] <= rd_data;
                            if (cap_last) begin
                                win_valid <= 1'b1;
                                state     <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!enable) begin
                        state     <= IDLE;
                        rd_en     <= 1'b0;
                        win_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else if (win_ready) begin
                        win_valid <= 1'b0;
                        if (last_pos) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            win_row <= nxt_row;
                            win_col <= nxt_col;
                            state   <= FETCH;
                            rd_en   <= 1'b1;
`ifdef WINDOW_REUSE_EN
                            if (!wrap) begin
                                for (int k = 0; k < WN - 1; k++) begin
                                    if ((k % KERNEL) != KERNEL - 1) begin
                                        window[k] <= window[k+1];
                                    end
                                end
                                reuse   <= 1'b1;
                                iss_i   <= '0;
                                iss_j   <= KL;
                                rd_addr <= addr_of(nxt_row, nxt_col, '0, KL);
                            end else begin
`else
                            begin
`endif
                                reuse   <= 1'b0;
                                iss_i   <= '0;
                                iss_j   <= '0;
                                rd_addr <= addr_of(nxt_row, nxt_col, '0, '0);
                            end
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_fetcher.sv
// Randomized bench for window_fetcher against a queue-based address/data model.
// Honors WINDOW_REUSE_EN for expected read sequences and latencies.
module tb_window_fetcher;

    localparam int DS = 16;
    localparam int IW = 6;
    localparam int AW = 10;
    localparam int K  = 5;
`ifdef WINDOW_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [IW-1:0] img_size = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DS-1:0] rd_data = '0;
    logic [DS-1:0] window [0:K*K-1];
    logic          win_valid;
    logic          win_ready = 1'b0;
    logic [IW-1:0] win_row;
    logic [IW-1:0] win_col;
    logic          busy;
    logic          done;
    logic          err;

    logic [DS-1:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    window_fetcher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .imgSize   (img_size),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .window    (window),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_row   (win_row),
        .win_col   (win_col),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_win(input string tag, input int n, input int r,
                           input int c);
        for (int k = 0; k < K * K; k++) begin
            chk(tag, 32'(window[k]), 32'(mem[(r + k / K) * n + c + k % K]));
        end
    endtask

    task automatic fill_mem(input bit ident);
        for (int a = 0; a < 1024; a++) begin
            mem[a] = ident ? 16'(a) : 16'($urandom);
        end
    endtask

    task automatic run_img(input int n, input int pct, input bit ident,
                           input int hold_first);
        int m, r, c, cnt, evt, hold, nwin;
        int q[$];
        bit prev_v, fin;
        m = n - K + 1;
        fill_mem(ident);
        r = 0;
        c = 0;
        q = {};
        for (int i = 0; i < K * K; i++) q.push_back((i / K) * n + i % K);
        @(negedge clk);
        img_size  = IW'(n);
        enable    = 1'b1;
        win_ready = 1'b0;
        cnt = 0; evt = 1; prev_v = 0; fin = 0; nwin = 0; hold = 0;
        while (!fin && cnt < 60 * n * n + 100) begin
            @(negedge clk);
            cnt++;
            img_size = IW'($urandom);
            if (rd_en) begin
                if (q.size() == 0) chk("rd_extra", 32'(rd_addr), 32'hFFFF_FFFF);
                else chk("rd_addr", 32'(rd_addr), 32'(q.pop_front()));
            end
            if (win_valid) begin
                if (!prev_v) begin
                    chk("latency", 32'(cnt - evt),
                        (REUSE && nwin > 0 && c != 0) ? 32'd6 : 32'd26);
                    chk_win("win_data", n, r, c);
                    if (nwin == 0 && hold_first > 0) hold = hold_first;
                end
                chk("win_row", 32'(win_row), 32'(r));
                chk("win_col", 32'(win_col), 32'(c));
                chk("hold_rd", 32'(rd_en), 32'd0);
                chk("busy", 32'(busy), 32'd1);
            end
            win_ready = (hold > 0) ? 1'b0 : ($urandom_range(99) < pct);
            if (hold > 0) hold--;
            prev_v = win_valid;
            if (win_valid && win_ready) begin
                chk_win("win_stable", n, r, c);
                nwin++;
                evt = cnt + 1;
                if (r == m - 1 && c == m - 1) begin
                    fin = 1;
                end else begin
                    c++;
                    if (c == m) begin
                        c = 0;
                        r++;
                        for (int i = 0; i < K * K; i++)
                            q.push_back((r + i / K) * n + c + i % K);
                    end else if (REUSE) begin
                        for (int i = 0; i < K; i++)
                            q.push_back((r + i) * n + c + K - 1);
                    end else begin
                        for (int i = 0; i < K * K; i++)
                            q.push_back((r + i / K) * n + c + i % K);
                    end
                end
            end
        end
        if (!fin) chk("timeout", 32'(cnt), 32'd0);
        @(negedge clk);
        win_ready = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("err_ok", 32'(err), 32'd0);
        chk("valid_done", 32'(win_valid), 32'd0);
        chk("windows", 32'(nwin), 32'(m * m));
        chk("rd_left", 32'(q.size()), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        chk("done_clr", 32'(done), 32'd0);
    endtask

    task automatic run_bad(input int n);
        @(negedge clk);
        img_size = IW'(n);
        enable   = 1'b1;
        @(negedge clk);
        chk("bad_done", 32'(done), 32'd1);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        repeat (3) begin
            chk("bad_rd", 32'(rd_en), 32'd0);
            @(negedge clk);
        end
        chk("bad_hold", 32'(done), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("bad_clr_done", 32'(done), 32'd0);
        chk("bad_clr_err", 32'(err), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd"}, 32'(rd_en), 32'd0);
        chk({tag, "_valid"}, 32'(win_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        int reads, wait_n;
        fill_mem(1'b1);
        #2;
        chk_idle("rst");
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_row", 32'(win_row), 32'd0);
        chk("rst_win", 32'(window[7]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_img(5, 100, 1'b1, 0);
        run_img(6, 100, 1'b1, 0);
        run_img(6, 50, 1'b1, 0);
        run_img(8, 100, 1'b0, 10);
        run_bad(4);
        run_bad(33);
        run_bad($urandom_range(0, 4));
        run_bad($urandom_range(33, 63));

        // Reset in the middle of the first window's fetch.
        fill_mem(1'b1);
        @(negedge clk);
        img_size = IW'(6);
        enable = 1'b1;
        reads = 0;
        for (int t = 0; t < 100 && reads < 12; t++) begin
            @(negedge clk);
            if (rd_en) reads++;
        end
        chk("rst_reads", 32'(reads), 32'd12);
        rst_n = 1'b0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_addr", 32'(rd_addr), 32'd0);
        chk("mid_rst_win", 32'(window[10]), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_img(6, 100, 1'b1, 0);

        // Abort by dropping enable partway through a run.
        fill_mem(1'b0);
        @(negedge clk);
        img_size = IW'(7);
        enable = 1'b1;
        wait_n = $urandom_range(3, 60);
        repeat (wait_n) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk_idle("abort");
        @(negedge clk);
        chk("abort_rd2", 32'(rd_en), 32'd0);

        for (int t = 0; t < 3; t++) begin
            run_img($urandom_range(5, 12), $urandom_range(30, 100), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_fetcher.md
WINDOW_FETCHER -- requirements
Module: window_fetcher

Interface
REQ-001 SHALL have parameter DATA_SIZE, 16, pixel word width.
REQ-002 SHALL have parameter IMG_SIZE_WIDTH, 6, width of imgSize and of the window position outputs.
REQ-003 SHALL have parameter BUF_ADDR_SIZE, 10, image-buffer address width (1024 words).
REQ-004 SHALL have parameter KERNEL, 5, window edge length (window = 25 words).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, run request (level).
REQ-008 SHALL have port imgSize, input, IMG_SIZE_WIDTH, square image edge N.
REQ-009 SHALL have port rd_en, output, 1, image-buffer read strobe.
REQ-010 SHALL have port rd_addr, output, BUF_ADDR_SIZE, read address.
REQ-011 SHALL have port rd_data, input, DATA_SIZE, read data, valid one cycle after rd_en.
REQ-012 SHALL have port window, output, DATA_SIZE x 25 unpacked array [0:24], row-major KERNELxKERNEL window.
REQ-013 SHALL have port win_valid, output, 1, window holds a complete window.
REQ-014 SHALL have port win_ready, input, 1, consumer accepts the window.
REQ-015 SHALL have port win_row, output, IMG_SIZE_WIDTH, top-left row of the current window.
REQ-016 SHALL have port win_col, output, IMG_SIZE_WIDTH, top-left column of the current window.
REQ-017 SHALL have port busy, output, 1, high in FETCH or HOLD.
REQ-018 SHALL have port done, output, 1, run complete.
REQ-019 SHALL have port err, output, 1, illegal imgSize.

Function
REQ-020 SHALL implement states IDLE, FETCH, HOLD, DONE.
REQ-021 IDLE: enable=1 at an edge SHALL latch N from imgSize, set row=col=0, and enter FETCH; if N<5 or N>32, SHALL instead enter DONE with err=1.
REQ-022 Output grid SHALL be M=N-4 per side; window (r,c) pixel (i,j) SHALL be buffer address (r+i)*N+(c+j), computed at BUF_ADDR_SIZE width.
REQ-023 FETCH (full): SHALL issue 25 reads on consecutive cycles in row-major order (i outer, j inner), one per cycle; rd_en SHALL be low outside issued reads.
REQ-024 rd_data SHALL be captured one cycle after each rd_en into window[i*5+j].
REQ-025 win_valid SHALL rise on the edge capturing the last datum; state becomes HOLD; latency from start edge to win_valid high is 26 cycles.
REQ-026 HOLD: window, win_row, win_col SHALL stay stable while win_valid=1 and win_ready=0.
REQ-027 Transfer SHALL occur on an edge with win_valid=1 and win_ready=1; win_valid SHALL drop on that edge.
REQ-028 After transfer: if c<M-1 then c+1; else c=0, r+1; if (r,c) was (M-1,M-1), SHALL enter DONE, otherwise FETCH.
REQ-029 DONE: done=1, busy=0; SHALL hold until enable=0, then IDLE with done=0, err=0.
REQ-030 enable=0 in FETCH or HOLD SHALL abort to IDLE on the next edge: win_valid=0, done=0, outstanding read data discarded.
REQ-031 imgSize changes after start SHALL be ignored until the next run.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE; rd_en, win_valid, busy, done, err = 0; rd_addr, win_row, win_col = 0; window contents = 0.
REQ-033 Reset mid-FETCH SHALL discard partial windows; the first run after reset SHALL behave identically to a run from power-up.

Configuration
REQ-034 Macro WINDOW_REUSE_EN SHALL select column reuse.
REQ-035 With WINDOW_REUSE_EN defined: a transfer advancing c without row wrap SHALL shift window left one column (window[i*5+j] <= window[i*5+j+1]) and read only the 5 new pixels (column c+4, i=0..4); win_valid SHALL rise 6 cycles after the transfer edge. Row wrap and first window SHALL use the full 25-read fetch.
REQ-036 Without WINDOW_REUSE_EN: every window SHALL use the full 25-read fetch; no shift logic present.

Verification
REQ-037 N=5, buffer[a]=a, win_ready=1 -> one window, window[k]=k, row=col=0, done=1 thereafter, err=0.
REQ-038 N=6, buffer[a]=a, win_ready=1 -> 4 windows in order (0,0),(0,1),(1,0),(1,1); window(1,1)[0]=7, window(1,1)[24]=35.
REQ-039 N=6, WINDOW_REUSE_EN -> window 2 reads only addresses 5,11,17,23,29; win_valid 6 cycles after first transfer.
REQ-040 N=8, win_ready held 0 for 10 cycles at first win_valid -> window/win_row/win_col unchanged, no rd_en, then normal continuation.
REQ-041 N=4 and N=33 -> DONE next cycle with err=1, no rd_en ever asserted.
REQ-042 rst_n=0 at read 12 of window (0,0), released, enable=1 -> clean restart; first window matches REQ-038 values.
